// File: rtl/calc_core_frame_sequencer.sv
// Frame sequencer around the calculation core: counts the incoming window
// stream, forwards only interior windows to the core, counts results, checks
// pure/edge lock-step, and reports frame completion or a drain timeout.
module calc_core_frame_sequencer #(
  parameter int unsigned WIDTH         = 640,
  parameter int unsigned HEIGHT        = 480,
  parameter int unsigned BORDER        = 2,
  parameter int unsigned DRAIN_TIMEOUT = 8192,
  localparam int unsigned CW  = $clog2(WIDTH),
  localparam int unsigned RW  = $clog2(HEIGHT),
  localparam int unsigned NW  = $clog2(WIDTH * HEIGHT + 1),
  localparam int unsigned EXP = (WIDTH - 2 * BORDER) * (HEIGHT - 2 * BORDER),
  localparam int unsigned TW  = $clog2(DRAIN_TIMEOUT + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_frame_start,
  input  logic          i_win_valid,
  output logic          o_core_valid,
  input  logic          i_pure_valid,
  input  logic          i_edge_valid,
  output logic          o_busy,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic [NW-1:0] o_out_count,
  output logic          o_frame_done,
  output logic          o_mismatch,
  output logic          o_overrun,
  output logic          o_timeout
);

  typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [NW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          core_valid_q, core_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          mismatch_q, mismatch_d;
  logic          overrun_q, overrun_d;
  logic          timeout_q, timeout_d;

  logic start_frame;
  logic col_last, row_last, interior;

  assign col_last = (col_q == CW'(WIDTH - 1));
  assign row_last = (row_q == RW'(HEIGHT - 1));
  assign interior = (col_q >= CW'(BORDER)) && (col_q <= CW'(WIDTH - 1 - BORDER)) &&
                    (row_q >= RW'(BORDER)) && (row_q <= RW'(HEIGHT - 1 - BORDER));

  // Next-state, counters and sticky status for the frame FSM.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    count_d      = count_q;
    timer_d      = timer_q;
    core_valid_d = 1'b0;
    done_d       = 1'b0;
    mismatch_d   = mismatch_q;
    overrun_d    = overrun_q;
    timeout_d    = timeout_q;
    start_frame  = 1'b0;

    unique case (state_q)
      StIdle: start_frame = i_frame_start;
      StFeed: begin
        // Start is ignored here, including on the final pixel.
        if (i_win_valid) begin
          core_valid_d = interior;
          if (col_last) begin
            col_d = '0;
            if (row_last) begin
              row_d   = '0;
              state_d = StDrain;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StDrain: begin
        timer_d = timer_q + 1'b1;
        if (i_win_valid) overrun_d = 1'b1;
        // A complete result count takes priority over the timeout.
        if (count_q == NW'(EXP)) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (timer_q == TW'(DRAIN_TIMEOUT - 1)) begin
          state_d   = StDone;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      StDone: start_frame = i_frame_start;
      default: state_d = StIdle;
    endcase

    // Results are counted and lock-step checked only while the frame is live.
    if (state_q == StFeed || state_q == StDrain) begin
      if (i_edge_valid && (count_q != {NW{1'b1}})) count_d = count_q + 1'b1;
      if (i_pure_valid != i_edge_valid) mismatch_d = 1'b1;
    end

    if (start_frame) begin
      state_d    = StFeed;
      col_d      = '0;
      row_d      = '0;
      count_d    = '0;
      timer_d    = '0;
      mismatch_d = 1'b0;
      overrun_d  = 1'b0;
      timeout_d  = 1'b0;
    end

    busy_d = (state_d == StFeed) || (state_d == StDrain);
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      count_q      <= '0;
      timer_q      <= '0;
      core_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mismatch_q   <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
      core_valid_q <= core_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mismatch_q   <= mismatch_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign o_core_valid = core_valid_q;
  assign o_busy       = busy_q;
  assign o_col        = col_q;
  assign o_row        = row_q;
  assign o_out_count  = count_q;
  assign o_frame_done = done_q;
  assign o_mismatch   = mismatch_q;
  assign o_overrun    = overrun_q;
  assign o_timeout    = timeout_q;

endmodule
